// File: rtl/tile_line_renderer.sv
`timescale 1ns/1ps
// tile_line_renderer: maps VGA pixel coordinates to map-tile colours.
// A fetch FSM prefetches whole block rows of tile colours into a
// two-bank line buffer, so the pixel path never waits on the map.
// Ports:
//   clk, rst_n           pixel clock, asynchronous active-low reset
//   pixel_read, vga_rx,  pixel request and coordinates from VGA timing
//   vga_ry
//   R, G, B              registered colour, 1-cycle latency
//   renderer_rx/ry,      map fetch address (tile column / row)
//   mapa_read,           map request, accepted by mapa_valid
//   mapa_valid
//   mapa_R/G/B           tile colour returned by the map
//   fetch_overrun        sticky: a pixel hit a row that was not loaded
// Optional feature: define GRID_OVERLAY_EN to draw all-ones grid lines
// on the first pixel column and line of every tile.
module tile_line_renderer #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int BLOCK_BITS    = 4,
    parameter int BLOCK_SIZE    = 16,
    parameter int COLOR_BITS    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pixel_read,
    input  logic [9:0]            vga_rx,
    input  logic [9:0]            vga_ry,
    output logic [COLOR_BITS-1:0] R,
    output logic [COLOR_BITS-1:0] G,
    output logic [COLOR_BITS-1:0] B,
    output logic [9:0]            renderer_rx,
    output logic [9:0]            renderer_ry,
    output logic                  mapa_read,
    input  logic                  mapa_valid,
    input  logic [COLOR_BITS-1:0] mapa_R,
    input  logic [COLOR_BITS-1:0] mapa_G,
    input  logic [COLOR_BITS-1:0] mapa_B,
    output logic                  fetch_overrun
);

    localparam int COLS  = SCREEN_WIDTH / BLOCK_SIZE;
    localparam int ROWS  = SCREEN_HEIGHT >> BLOCK_BITS;
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int PIX_W = 3 * COLOR_BITS;

    localparam logic [9:0]       RX_LIM   = 10'(SCREEN_WIDTH);
    localparam logic [9:0]       RY_LIM   = 10'(SCREEN_HEIGHT);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t                  state_q, state_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [ROW_W-1:0]        tgt_q, tgt_d;
    logic [1:0][ROW_W-1:0]   tag_q, tag_d;
    logic [1:0]              vld_q, vld_d;
    logic                    mapa_read_q, mapa_read_d;
    logic [PIX_W-1:0]        rgb_q, rgb_d;
    logic                    ovr_q, ovr_d;

    logic [PIX_W-1:0]        line_mem [2][COLS];
    logic                    wr_en;

    logic [ROW_W-1:0]        cur_row;
    logic [ROW_W-1:0]        nxt_row;
    logic [ROW_W-1:0]        fetch_row;
    logic                    cur_hit;
    logic                    nxt_hit;
    logic                    in_range;
    logic [COL_W-1:0]        pix_col;

    // Row bookkeeping. During vertical blanking the beam is treated as
    // sitting on the last row, so the prefetcher readies row 0 for the
    // next frame instead of chasing rows beyond the map.
    always_comb begin
        cur_row = ROW_W'(vga_ry >> BLOCK_BITS);
        if (vga_ry >= RY_LIM) begin
            cur_row = LAST_ROW;
        end
        nxt_row = (cur_row == LAST_ROW) ? '0 : cur_row + ROW_W'(1);
        cur_hit = vld_q[cur_row[0]] && (tag_q[cur_row[0]] == cur_row);
        nxt_hit = vld_q[nxt_row[0]] && (tag_q[nxt_row[0]] == nxt_row);
        fetch_row = cur_hit ? nxt_row : cur_row;
    end

    // Fetch FSM next state. The current row always has priority over
    // the prefetch; a fetch in flight is never abandoned.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        tgt_d       = tgt_q;
        tag_d       = tag_q;
        vld_d       = vld_q;
        mapa_read_d = mapa_read_q;
        wr_en       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!cur_hit || !nxt_hit) begin
                    tgt_d               = fetch_row;
                    vld_d[fetch_row[0]] = 1'b0;
                    col_d               = '0;
                    mapa_read_d         = 1'b1;
                    state_d             = REQ;
                end
            end
            REQ: begin
                if (mapa_read_q && mapa_valid) begin
                    wr_en = 1'b1;
                    if (col_q == LAST_COL) begin
                        tag_d[tgt_q[0]] = tgt_q;
                        vld_d[tgt_q[0]] = 1'b1;
                        mapa_read_d     = 1'b0;
                        state_d         = IDLE;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
        endcase
    end

    // Pixel path: one-cycle registered lookup into the bank that holds
    // the current block row.
    always_comb begin
        in_range = pixel_read && (vga_rx < RX_LIM) && (vga_ry < RY_LIM);
        pix_col  = COL_W'(vga_rx >> BLOCK_BITS);
        rgb_d    = '0;
        ovr_d    = ovr_q;
        if (in_range) begin
            if (cur_hit) begin
                rgb_d = line_mem[cur_row[0]][pix_col];
            end else begin
                ovr_d = 1'b1;
            end
`ifdef GRID_OVERLAY_EN
            if ((vga_rx[BLOCK_BITS-1:0] == '0) ||
                (vga_ry[BLOCK_BITS-1:0] == '0)) begin
                rgb_d = '1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            tgt_q       <= '0;
            tag_q       <= '0;
            vld_q       <= '0;
            mapa_read_q <= 1'b0;
            rgb_q       <= '0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            tgt_q       <= tgt_d;
            tag_q       <= tag_d;
            vld_q       <= vld_d;
            mapa_read_q <= mapa_read_d;
            rgb_q       <= rgb_d;
            ovr_q       <= ovr_d;
        end
    end

    // Buffer storage has no reset; the bank valid bits guard its use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_mem[tgt_q[0]][col_q] <= {mapa_R, mapa_G, mapa_B};
        end
    end

    assign R             = rgb_q[PIX_W-1 -: COLOR_BITS];
    assign G             = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
    assign B             = rgb_q[COLOR_BITS-1:0];
    assign renderer_rx   = 10'(col_q);
    assign renderer_ry   = 10'(tgt_q);
    assign mapa_read     = mapa_read_q;
    assign fetch_overrun = ovr_q;

endmodule

// File: tb/tb_tile_line_renderer.sv
`timescale 1ns/1ps
// Bench for tile_line_renderer: directed stimulus, pixel results checked
// by a scoreboard monitor; handshake/flag checks made inline.
module tb_tile_line_renderer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pixel_read;
    logic [9:0] vga_rx;
    logic [9:0] vga_ry;
    logic [1:0] R, G, B;
    logic [9:0] renderer_rx;
    logic [9:0] renderer_ry;
    logic       mapa_read;
    logic       mapa_valid;
    logic [1:0] mapa_R, mapa_G, mapa_B;
    logic       fetch_overrun;

    int n_chk  = 0;
    int n_pass = 0;
    int pix_n  = 0;

    logic [5:0] exp_q[$];
    int         id_q[$];

    always #5 clk = ~clk;

    tile_line_renderer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pixel_read    (pixel_read),
        .vga_rx        (vga_rx),
        .vga_ry        (vga_ry),
        .R             (R),
        .G             (G),
        .B             (B),
        .renderer_rx   (renderer_rx),
        .renderer_ry   (renderer_ry),
        .mapa_read     (mapa_read),
        .mapa_valid    (mapa_valid),
        .mapa_R        (mapa_R),
        .mapa_G        (mapa_G),
        .mapa_B        (mapa_B),
        .fetch_overrun (fetch_overrun)
    );

    // Map contents: R = col, G = col ^ row, B = col + row (2 bits each).
    // Row 0 therefore reads back col on every channel.
    function automatic logic [5:0] map_rgb(input logic [9:0] c,
                                           input logic [9:0] r);
        logic [1:0] rr, gg, bb;
        rr = c[1:0];
        gg = c[1:0] ^ r[1:0];
        bb = c[1:0] + r[1:0];
        return {rr, gg, bb};
    endfunction

    // Junk on the data bus while not valid.
    assign {mapa_R, mapa_G, mapa_B} =
        mapa_valid ? map_rgb(renderer_rx, renderer_ry) : 6'b101010;

    function automatic logic [5:0] exp_pix(input logic [9:0] x,
                                           input logic [9:0] y,
                                           input bit loaded);
        logic [5:0] e;
        e = loaded ? map_rgb(x >> 4, y >> 4) : 6'd0;
`ifdef GRID_OVERLAY_EN
        if (x[3:0] == 4'd0 || y[3:0] == 4'd0) e = 6'h3f;
`endif
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int want);
        n_chk++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, act, want);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y,
                       input logic [5:0] e);
        vga_rx     = x;
        vga_ry     = y;
        pixel_read = 1'b1;
        exp_q.push_back(e);
        id_q.push_back(pix_n);
        pix_n++;
        step(1);
        pixel_read = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 200 && mapa_read; i++) step(1);
        chk(nm, int'(mapa_read), 0);
    endtask

    // Scoreboard monitor: a request captured at a rising edge is
    // compared against the queue head on the following falling edge.
    initial begin : monitor
        logic       cap;
        logic [5:0] e;
        int         id;
        forever begin
            @(posedge clk);
            cap = pixel_read && rst_n;
            @(negedge clk);
            if (cap) begin
                if (exp_q.size() == 0) begin
                    chk("pix_unexpected", exp_q.size(), 1);
                end else begin
                    e  = exp_q.pop_front();
                    id = id_q.pop_front();
                    n_chk++;
                    if ({R, G, B} === e) n_pass++;
                    else $display("FAIL pix%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                                  id, R, G, B, e[5:4], e[3:2], e[1:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: run did not finish, %0d/%0d so far",
                 n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n      = 1'b0;
        pixel_read = 1'b0;
        vga_rx     = '0;
        vga_ry     = '0;
        mapa_valid = 1'b1;
        step(3);
        chk("rst_rgb",  int'({R, G, B}), 0);
        chk("rst_read", int'(mapa_read), 0);
        chk("rst_rx",   int'(renderer_rx), 0);
        chk("rst_ry",   int'(renderer_ry), 0);
        chk("rst_ovr",  int'(fetch_overrun), 0);

        // First frame: row 0 fetch starts on the first edge.
        rst_n = 1'b1;
        pix(10'd700, 10'd5, 6'd0);
        chk("oor_ovr",     int'(fetch_overrun), 0);
        chk("fetch0_read", int'(mapa_read), 1);
        chk("fetch0_ry",   int'(renderer_ry), 0);
        step(39);
        // Captured on edge 41: row 0 valid only after that edge.
        pix(10'd37, 10'd5, exp_pix(10'd37, 10'd5, 1'b0));
        chk("early_ovr", int'(fetch_overrun), 1);
        chk("gap_idle",  int'(mapa_read), 0);
        pix(10'd37, 10'd5, exp_pix(10'd37, 10'd5, 1'b1));
        chk("fetch1_read", int'(mapa_read), 1);
        chk("fetch1_ry",   int'(renderer_ry), 1);
        chk("fetch1_rx",   int'(renderer_rx), 0);

        // Stall row 1 on column 5 for three cycles.
        step(5);
        chk("stall_rx0", int'(renderer_rx), 5);
        mapa_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("stall_rx",   int'(renderer_rx), 5);
            chk("stall_read", int'(mapa_read), 1);
        end
        mapa_valid = 1'b1;
        step(1);
        chk("stall_rel_rx", int'(renderer_rx), 6);
        wait_idle("row1_done");

        pix(10'd639, 10'd15, exp_pix(10'd639, 10'd15, 1'b1));
        step(2);
        chk("steady_idle", int'(mapa_read), 0);

        // Advance to row 1: row 2 prefetch into bank 0.
        pix(10'd100, 10'd16, exp_pix(10'd100, 10'd16, 1'b1));
        chk("adv_read", int'(mapa_read), 1);
        chk("adv_ry",   int'(renderer_ry), 2);
        chk("adv_rx",   int'(renderer_rx), 0);
        pix(10'd90,  10'd20, exp_pix(10'd90,  10'd20, 1'b1));
        pix(10'd630, 10'd31, exp_pix(10'd630, 10'd31, 1'b1));
        wait_idle("row2_done");
        pix(10'd200, 10'd40, exp_pix(10'd200, 10'd40, 1'b1));
        wait_idle("row3_done");

        // Last row: fetch 29, then wrap prefetch of row 0.
        vga_ry = 10'd464;
        step(1);
        chk("r29_ry",   int'(renderer_ry), 29);
        chk("r29_read", int'(mapa_read), 1);
        wait_idle("row29_done");
        step(1);
        chk("wrap_read", int'(mapa_read), 1);
        chk("wrap_ry",   int'(renderer_ry), 0);
        wait_idle("wrap_done");
        pix(10'd330, 10'd470, exp_pix(10'd330, 10'd470, 1'b1));
        pix(10'd500, 10'd479, exp_pix(10'd500, 10'd479, 1'b1));

        // Reset in the middle of a row 1 fetch.
        vga_ry = 10'd0;
        for (int i = 0; i < 100 && renderer_rx != 10'd20; i++) step(1);
        chk("mid_rx", int'(renderer_rx), 20);
        chk("mid_ry", int'(renderer_ry), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_read", int'(mapa_read), 0);
        chk("arst_ovr",  int'(fetch_overrun), 0);
        chk("arst_rx",   int'(renderer_rx), 0);
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("refetch_read", int'(mapa_read), 1);
        chk("refetch_ry",   int'(renderer_ry), 0);
        chk("refetch_rx",   int'(renderer_rx), 0);
        step(1);
        chk("refetch_rx1",  int'(renderer_rx), 1);
        wait_idle("refetch_done");
        pix(10'd32, 10'd7, exp_pix(10'd32, 10'd7, 1'b1));
        pix(10'd100, 10'd500, 6'd0);
        step(2);
        chk("post_rst_ovr", int'(fetch_overrun), 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
